// File: rtl/zif_pulse_sequencer.sv
// Sequences one timed PGM pulse on the ZIF socket per start command (osc domain).
// Optional: define ZIF_PULSE_AUTOINC_EN to post-increment zif_addr at the end of each sequence.
module zif_pulse_sequencer #(
    parameter int unsigned CNT_WIDTH   = 16,
    parameter int unsigned HOLD_CYCLES = 4,
    parameter logic [15:0] PULSE_RESET = 16'd240,
    parameter logic [7:0]  SETUP_RESET = 8'd12
) (
    input  logic        osc,
    input  logic        rst,
    input  logic        cmd_valid,
    input  logic [7:0]  cmd_addr,
    input  logic [7:0]  cmd_data,
    output logic [15:0] zif_addr,
    output logic [7:0]  zif_data,
    output logic        zif_data_oe,
    output logic        pgm_n,
    output logic        busy,
    output logic        done,
    output logic [7:0]  status
);

    typedef enum logic [2:0] {StIdle, StSetup, StPulse, StHold, StDone} state_e;

    state_e               state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [15:0]          addr_q, addr_d;
    logic [7:0]           data_q, data_d;
    logic [7:0]           setup_q, setup_d;
    logic [15:0]          pulse_q, pulse_d;
    logic                 overrun_q, overrun_d;
    logic                 done_flag_q, done_flag_d;
    logic                 busy_q, busy_d;
    logic                 oe_q, oe_d;
    logic                 pgm_n_q, pgm_n_d;
    logic                 done_q, done_d;

    logic                 in_seq;
    logic                 wr_cfg;
    logic                 wr_ctrl;
    logic                 start_req;
    logic                 clr_req;
    logic                 start_ok;
    logic                 cnt_zero;
    logic [CNT_WIDTH-1:0] setup_load;
    logic [CNT_WIDTH-1:0] pulse_load;
    logic [CNT_WIDTH-1:0] hold_load;

    assign in_seq    = (state_q == StSetup) || (state_q == StPulse) || (state_q == StHold);
    assign wr_cfg    = cmd_valid && (cmd_addr >= 8'h10) && (cmd_addr <= 8'h15);
    assign wr_ctrl   = cmd_valid && (cmd_addr == 8'h16);
    assign start_req = wr_ctrl && cmd_data[0];
    assign clr_req   = wr_ctrl && cmd_data[1];
    // DONE counts as not busy, so a start there chains straight into SETUP.
    assign start_ok  = start_req && !in_seq;
    assign cnt_zero  = (cnt_q == '0);

    // A programmed length of 0 behaves as 1 rather than wrapping.
    assign setup_load = (setup_q == 8'd0)  ? '0 : CNT_WIDTH'(setup_q - 8'd1);
    assign pulse_load = (pulse_q == 16'd0) ? '0 : CNT_WIDTH'(pulse_q - 16'd1);
    assign hold_load  = CNT_WIDTH'(HOLD_CYCLES - 1);

    always_ff @(posedge osc) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            StIdle: begin
                if (start_ok) begin
                    state_d = StSetup;
                    cnt_d   = setup_load;
                end
            end
            StSetup: begin
                if (cnt_zero) begin
                    state_d = StPulse;
                    cnt_d   = pulse_load;
                end else begin
                    cnt_d = cnt_q - CNT_WIDTH'(1);
                end
            end
            StPulse: begin
                if (cnt_zero) begin
                    state_d = StHold;
                    cnt_d   = hold_load;
                end else begin
                    cnt_d = cnt_q - CNT_WIDTH'(1);
                end
            end
            StHold: begin
                if (cnt_zero) begin
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q - CNT_WIDTH'(1);
                end
            end
            StDone: begin
                if (start_ok) begin
                    state_d = StSetup;
                    cnt_d   = setup_load;
                end else begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // Pin outputs are registered from the next state so pgm_n cannot glitch.
        busy_d  = (state_d == StSetup) || (state_d == StPulse) || (state_d == StHold);
        oe_d    = busy_d;
        pgm_n_d = (state_d != StPulse);
        done_d  = (state_d == StDone);
    end

    always_comb begin
        addr_d      = addr_q;
        data_d      = data_q;
        setup_d     = setup_q;
        pulse_d     = pulse_q;
        overrun_d   = overrun_q;
        done_flag_d = done_flag_q;

`ifdef ZIF_PULSE_AUTOINC_EN
        if (state_q == StDone) begin
            addr_d = addr_q + 16'd1;
        end
`endif

        if (wr_cfg && !in_seq) begin
            case (cmd_addr)
                8'h10:   data_d        = cmd_data;
                8'h11:   addr_d[7:0]   = cmd_data;
                8'h12:   addr_d[15:8]  = cmd_data;
                8'h13:   setup_d       = cmd_data;
                8'h14:   pulse_d[7:0]  = cmd_data;
                8'h15:   pulse_d[15:8] = cmd_data;
                default: ;
            endcase
        end

        if (clr_req) begin
            overrun_d   = 1'b0;
            done_flag_d = 1'b0;
        end
        if (in_seq && (wr_cfg || start_req)) begin
            overrun_d = 1'b1;
        end
        if (state_q == StDone) begin
            done_flag_d = 1'b1;
        end
    end

    always_ff @(posedge osc) begin
        if (rst) begin
            addr_q      <= 16'h0000;
            data_q      <= 8'h00;
            setup_q     <= SETUP_RESET;
            pulse_q     <= PULSE_RESET;
            overrun_q   <= 1'b0;
            done_flag_q <= 1'b0;
            busy_q      <= 1'b0;
            oe_q        <= 1'b0;
            pgm_n_q     <= 1'b1;
            done_q      <= 1'b0;
        end else begin
            addr_q      <= addr_d;
            data_q      <= data_d;
            setup_q     <= setup_d;
            pulse_q     <= pulse_d;
            overrun_q   <= overrun_d;
            done_flag_q <= done_flag_d;
            busy_q      <= busy_d;
            oe_q        <= oe_d;
            pgm_n_q     <= pgm_n_d;
            done_q      <= done_d;
        end
    end

    assign zif_addr    = addr_q;
    assign zif_data    = data_q;
    assign zif_data_oe = oe_q;
    assign pgm_n       = pgm_n_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign status      = {5'b00000, overrun_q, done_flag_q, busy_q};

endmodule
